// File: rtl/bar_row_encoder_if.sv
// Note handoff from the bar row encoder to the tone generator.
// Valid/ready handshake carrying a 4-bit note code.
interface bar_row_encoder_if;
  logic [3:0] note_code;
  logic       note_valid;
  logic       note_ready;

  modport master (
    output note_code,
    output note_valid,
    input  note_ready
  );

  modport slave (
    input  note_code,
    input  note_valid,
    output note_ready
  );
endinterface

// File: rtl/bar_row_encoder.sv
// Tracks the VGA line stream by strobes and reports the keyboard bar row.
// Captures a key hit on a note row and hands its code to the tone generator.
module bar_row_encoder #(
  parameter int TOP       = 15,
  parameter int BAND_H    = 32,
  parameter int NUM_BANDS = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        line_strobe,
  input  logic        key_hit,
  output logic [3:0]  band_idx,
  output logic        in_band,
  output logic [10:0] row_flags,
  output logic        hit_dropped,
  bar_row_encoder_if.master note
);

  typedef enum logic [1:0] {
    IDLE,
    TOP_MARGIN,
    BANDS,
    BOTTOM
  } state_t;

  localparam logic [4:0] TOP_LAST  = (TOP > 0) ? 5'(TOP - 1) : 5'd0;
  localparam logic [4:0] LINE_LAST = 5'(BAND_H - 1);
  localparam logic [3:0] BAND_LAST = 4'(NUM_BANDS - 1);

  state_t     state, state_n;
  logic [4:0] line_cnt, line_n;
  logic [3:0] band_cnt, band_n;
  logic       in_n;
  logic [4:0] row_n, row_cur;
  logic       accept, capture, drop;

  // Returns {is_note_row, note_code}; gap bands give 0.
  function automatic logic [4:0] row_of(input logic [3:0] b);
    case (b)
      4'd0:    return 5'h10;
      4'd2:    return 5'h11;
      4'd3:    return 5'h12;
      4'd5:    return 5'h13;
      4'd6:    return 5'h14;
      4'd7:    return 5'h15;
      4'd9:    return 5'h16;
      4'd10:   return 5'h17;
      4'd12:   return 5'h18;
      4'd13:   return 5'h19;
      4'd14:   return 5'h1a;
      default: return 5'h00;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    line_n  = line_cnt;
    band_n  = band_cnt;
    if (frame_start) begin
      line_n  = '0;
      band_n  = '0;
      state_n = (TOP == 0) ? BANDS : TOP_MARGIN;
    end else if (line_strobe) begin
      case (state)
        TOP_MARGIN: begin
          if (line_cnt == TOP_LAST) begin
            state_n = BANDS;
            line_n  = '0;
            band_n  = '0;
          end else begin
            line_n = line_cnt + 5'd1;
          end
        end
        BANDS: begin
          if (line_cnt == LINE_LAST) begin
            line_n = '0;
            if (band_cnt == BAND_LAST) begin
              state_n = BOTTOM;
              band_n  = '0;
            end else begin
              band_n = band_cnt + 4'd1;
            end
          end else begin
            line_n = line_cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered from the next-state view of the line.
  assign in_n  = (state_n == BANDS);
  assign row_n = row_of(band_n);

  assign row_cur = row_of(band_idx);
  assign accept  = note.note_valid && note.note_ready;
  assign capture = key_hit && (row_flags != '0)
                   && (!note.note_valid || accept);
  assign drop    = key_hit && note.note_valid && !accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      line_cnt  <= '0;
      band_cnt  <= '0;
      band_idx  <= '0;
      in_band   <= 1'b0;
      row_flags <= '0;
    end else begin
      state     <= state_n;
      line_cnt  <= line_n;
      band_cnt  <= band_n;
      band_idx  <= in_n ? band_n : 4'd0;
      in_band   <= in_n;
      row_flags <= (in_n && row_n[4]) ? (11'd1 << row_n[3:0]) : 11'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      note.note_code  <= '0;
      note.note_valid <= 1'b0;
      hit_dropped     <= 1'b0;
    end else begin
      if (capture) begin
        note.note_code  <= row_cur[3:0];
        note.note_valid <= 1'b1;
      end else if (accept) begin
        note.note_valid <= 1'b0;
      end
      if (frame_start)
        hit_dropped <= 1'b0;
      else if (drop)
        hit_dropped <= 1'b1;
    end
  end

endmodule
